// File: rtl/ripple_add_sequencer.sv
// ripple_add_sequencer: time-shares one external W-bit ripple_adder slice
// between two requesters. Each accepted N-bit add is run least-significant
// slice first over S = N/W cycles, with the carry held in carry_q between
// slices. Round-robin arbitration in IDLE; valid/ready on request and response.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | no operation held; arbitration open, one requester may be accepted
//   RUN   | slice cnt_q of the latched operands is on the adder this cycle
//   DONE  | result registered and presented until the consumer takes it
module ripple_add_sequencer #(
  parameter int N = 24,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req0_ci,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic         req1_ci,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [N-1:0] resp_sum,
  output logic         resp_co,
  output logic         resp_id,
  output logic [W-1:0] slice_a,
  output logic [W-1:0] slice_b,
  output logic         slice_ci,
  input  logic [W-1:0] slice_sum,
  input  logic         slice_co,
  output logic         busy
);

  localparam int S  = N / W;
  localparam int CW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic           ci_q, ci_d;
  logic           id_q, id_d;
  logic           carry_q, carry_d;
  logic           last_grant_q, last_grant_d;
  logic [N-1:0]   sum_q, sum_d;
  logic           resp_valid_q, resp_valid_d;
  logic [N-1:0]   resp_sum_q, resp_sum_d;
  logic           resp_co_q, resp_co_d;
  logic           resp_id_q, resp_id_d;

  logic grant;
  logic accept;

  // Round-robin pick: the lone valid requester, or on a tie the one not granted last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else if (req1_valid)          grant = 1'b1;
  end

  // Readys are masked by reset so nothing is accepted in a reset cycle.
  assign req0_ready = (state_q == IDLE) & ~rst & req0_valid & ~grant;
  assign req1_ready = (state_q == IDLE) & ~rst & req1_valid &  grant;
  assign accept     = req0_ready | req1_ready;

  // Present the current slice to the external adder; quiet outside RUN.
  always_comb begin
    slice_a  = '0;
    slice_b  = '0;
    slice_ci = 1'b0;
    if (state_q == RUN) begin
      for (int k = 0; k < S; k++) begin
        if (cnt_q == CW'(k)) begin
          slice_a = a_q[k*W +: W];
          slice_b = b_q[k*W +: W];
        end
      end
      slice_ci = (cnt_q == '0) ? ci_q : carry_q;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    ci_d         = ci_q;
    id_d         = id_q;
    carry_d      = carry_q;
    last_grant_d = last_grant_q;
    sum_d        = sum_q;
    resp_valid_d = resp_valid_q;
    resp_sum_d   = resp_sum_q;
    resp_co_d    = resp_co_q;
    resp_id_d    = resp_id_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d          = req1_ready ? req1_a  : req0_a;
          b_d          = req1_ready ? req1_b  : req0_b;
          ci_d         = req1_ready ? req1_ci : req0_ci;
          id_d         = req1_ready;
          last_grant_d = req1_ready;
          carry_d      = 1'b0;
          cnt_d        = '0;
          state_d      = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < S; k++) begin
          if (cnt_q == CW'(k)) sum_d[k*W +: W] = slice_sum;
        end
        carry_d = slice_co;
        if (cnt_q == CW'(S-1)) begin
          cnt_d        = '0;
          resp_valid_d = 1'b1;
          resp_sum_d   = sum_d;
          resp_co_d    = slice_co;
          resp_id_d    = id_q;
          state_d      = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; synchronous reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      ci_q         <= 1'b0;
      id_q         <= 1'b0;
      carry_q      <= 1'b0;
      last_grant_q <= 1'b1;
      sum_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_sum_q   <= '0;
      resp_co_q    <= 1'b0;
      resp_id_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ci_q         <= ci_d;
      id_q         <= id_d;
      carry_q      <= carry_d;
      last_grant_q <= last_grant_d;
      sum_q        <= sum_d;
      resp_valid_q <= resp_valid_d;
      resp_sum_q   <= resp_sum_d;
      resp_co_q    <= resp_co_d;
      resp_id_q    <= resp_id_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_sum   = resp_sum_q;
  assign resp_co    = resp_co_q;
  assign resp_id    = resp_id_q;
  assign busy       = (state_q != IDLE);

endmodule
